// File: rtl/dsram_arbiter_pkg.sv
// Shared types and constants for the data-SRAM dual-pipe arbiter.
package dsram_arbiter_pkg;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned WENW = 4;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    DATA  = ST_DATA,
    DRAIN = ST_DRAIN
  } dsram_arb_state_t;

  typedef struct packed {
    logic            wr;
    logic [1:0]      size;
    logic [AW-1:0]   addr;
    logic [WENW-1:0] wen;
    logic [DW-1:0]   wdata;
  } dsram_req_t;

endpackage

// File: rtl/dsram_arbiter_if.sv
// Pipe-side requests and downstream SRAM bus of the data arbiter.
interface dsram_arbiter_if;
  import dsram_arbiter_pkg::*;

  logic            flush;
  logic            m_req;
  logic            s_req;
  logic [WENW-1:0] m_wen;
  logic [WENW-1:0] s_wen;
  logic [1:0]      m_rlen;
  logic [1:0]      s_rlen;
  logic [AW-1:0]   m_addr;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   m_rdata;
  logic [DW-1:0]   s_rdata;
  logic            stall;
  logic            data_req;
  logic            data_wr;
  logic [1:0]      data_size;
  logic [AW-1:0]   data_addr;
  logic [WENW-1:0] data_wen;
  logic [DW-1:0]   data_wdata;
  logic            data_addr_ok;
  logic            data_data_ok;
  logic [DW-1:0]   data_rdata;

  // Environment side: pipes plus downstream memory.
  modport master (
    output flush, m_req, s_req, m_wen, s_wen, m_rlen, s_rlen,
           m_addr, s_addr, m_wdata, s_wdata,
           data_addr_ok, data_data_ok, data_rdata,
    input  m_rdata, s_rdata, stall, data_req, data_wr, data_size,
           data_addr, data_wen, data_wdata
  );

  // Arbiter side.
  modport slave (
    input  flush, m_req, s_req, m_wen, s_wen, m_rlen, s_rlen,
           m_addr, s_addr, m_wdata, s_wdata,
           data_addr_ok, data_data_ok, data_rdata,
    output m_rdata, s_rdata, stall, data_req, data_wr, data_size,
           data_addr, data_wen, data_wdata
  );
endinterface

// File: rtl/dsram_arbiter_wen2size.sv
// Byte-enable pattern to access-size encoder for store requests.
module wen2size
  import dsram_arbiter_pkg::*;
(
  input  logic [WENW-1:0] i_wen,
  output logic [1:0]      o_size_c
);

  always_comb begin
    o_size_c = SIZE_B;
    case (i_wen)
      4'b1111:          o_size_c = SIZE_W;
      4'b0011, 4'b1100: o_size_c = SIZE_H;
      default:          o_size_c = SIZE_B;
    endcase
  end

endmodule

// File: rtl/dsram_arbiter.sv
// Serialises master/slave pipe accesses onto one data-SRAM bus in program order.
// Optional SAME_WORD_LOAD_MERGE_EN folds two same-word loads into one word read.
module dsram_arbiter
  import dsram_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  dsram_arbiter_if.slave  bus
);

  dsram_arb_state_t r_state;
  dsram_arb_state_t w_state_nxt;

  logic          r_m_done;
  logic          r_s_done;
  logic [DW-1:0] r_m_rdata;
  logic [DW-1:0] r_s_rdata;

  logic       w_m_pend;
  logic       w_s_pend;
  logic       w_sel_s;
  logic       w_merge;
  logic [3:0] w_sel_wen;
  logic [1:0] w_wen_size;
  dsram_req_t w_req;

  logic w_accept;
  logic w_xfer_ok;
  logic w_m_ok;
  logic w_s_ok;
  logic w_m_done_nxt;
  logic w_s_done_nxt;
  logic w_more;
  logic w_stall;
  logic w_m_rd;
  logic w_s_rd;

  // Master always wins while pending; slave only once master of the group is done.
  assign w_m_pend  = bus.m_req & ~r_m_done;
  assign w_s_pend  = bus.s_req & ~r_s_done;
  assign w_sel_s   = ~w_m_pend & w_s_pend;
  assign w_sel_wen = w_sel_s ? bus.s_wen : bus.m_wen;
  assign w_m_rd    = (bus.m_wen == '0);
  assign w_s_rd    = (bus.s_wen == '0);

`ifdef SAME_WORD_LOAD_MERGE_EN
  assign w_merge = w_m_pend & w_s_pend & w_m_rd & w_s_rd &
                   (bus.m_addr[AW-1:2] == bus.s_addr[AW-1:2]);
`else
  assign w_merge = 1'b0;
`endif

  wen2size u_wen2size (
    .i_wen    (w_sel_wen),
    .o_size_c (w_wen_size)
  );

  // Downstream payload of the currently selected requester.
  always_comb begin
    w_req       = '0;
    w_req.wr    = |w_sel_wen;
    w_req.wen   = w_sel_wen;
    w_req.addr  = w_sel_s ? bus.s_addr  : bus.m_addr;
    w_req.wdata = w_sel_s ? bus.s_wdata : bus.m_wdata;
    w_req.size  = w_req.wr ? w_wen_size : (w_sel_s ? bus.s_rlen : bus.m_rlen);
    if (w_merge) begin
      w_req.size = SIZE_W;
      w_req.addr = {bus.m_addr[AW-1:2], 2'b00};
    end
  end

  assign bus.data_req   = (r_state == ADDR) & ~bus.flush;
  assign bus.data_wr    = w_req.wr;
  assign bus.data_size  = w_req.size;
  assign bus.data_addr  = w_req.addr;
  assign bus.data_wen   = w_req.wen;
  assign bus.data_wdata = w_req.wdata;

  // Completion of a live (non-drained) transaction, including same-cycle addr/data ok.
  assign w_accept     = (r_state == ADDR) & ~bus.flush & bus.data_addr_ok;
  assign w_xfer_ok    = bus.data_data_ok & ~bus.flush & ((r_state == DATA) | w_accept);
  assign w_m_ok       = w_xfer_ok & w_m_pend;
  assign w_s_ok       = w_xfer_ok & (w_sel_s | w_merge);
  assign w_m_done_nxt = r_m_done | w_m_ok;
  assign w_s_done_nxt = r_s_done | w_s_ok;
  assign w_more       = (bus.m_req & ~w_m_done_nxt) | (bus.s_req & ~w_s_done_nxt);
  assign w_stall      = ~bus.flush & w_more;
  assign bus.stall    = w_stall;

  assign bus.m_rdata = (w_m_ok & w_m_rd) ? bus.data_rdata : r_m_rdata;
  assign bus.s_rdata = (w_s_ok & w_s_rd) ? bus.data_rdata : r_s_rdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (~bus.flush & (w_m_pend | w_s_pend)) w_state_nxt = ADDR;
      end
      ADDR: begin
        if (bus.flush)             w_state_nxt = IDLE;
        else if (bus.data_addr_ok) begin
          if (bus.data_data_ok)    w_state_nxt = w_more ? ADDR : IDLE;
          else                     w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.flush)             w_state_nxt = bus.data_data_ok ? IDLE : DRAIN;
        else if (bus.data_data_ok) w_state_nxt = w_more ? ADDR : IDLE;
      end
      DRAIN: begin
        if (bus.data_data_ok)      w_state_nxt = IDLE;
      end
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Done flags live until the group retires (stall low) or is flushed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m_done <= 1'b0;
      r_s_done <= 1'b0;
    end else if (bus.flush | ~w_stall) begin
      r_m_done <= 1'b0;
      r_s_done <= 1'b0;
    end else begin
      r_m_done <= w_m_done_nxt;
      r_s_done <= w_s_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m_rdata <= '0;
      r_s_rdata <= '0;
    end else begin
      if (w_m_ok & w_m_rd) r_m_rdata <= bus.data_rdata;
      if (w_s_ok & w_s_rd) r_s_rdata <= bus.data_rdata;
    end
  end

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed bench for dsram_arbiter; downstream requests checked against a scoreboard queue.
module tb_dsram_arbiter;
  import dsram_arbiter_pkg::*;

  logic clk;
  logic resetn;

  dsram_arbiter_if bus ();

  dsram_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [3:0] wen, input logic [31:0] wdata);
    exp_t e;
    e.wr = wr; e.size = size; e.addr = addr; e.wen = wen; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for data_req, then compare the payload with the scoreboard head.
  task automatic wait_req(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus.data_req !== 1'b1 && n < 20) begin
      step(); settle(); n++;
    end
    chk({tag, "_req"}, 32'(bus.data_req), 32'd1);
    chk({tag, "_stall_addr"}, 32'(bus.stall), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_wr"},   32'(bus.data_wr),   32'(e.wr));
      chk({tag, "_size"}, 32'(bus.data_size), 32'(e.size));
      chk({tag, "_addr"}, bus.data_addr,      e.addr);
      chk({tag, "_wen"},  32'(bus.data_wen),  32'(e.wen));
      if (e.wr) chk({tag, "_wdata"}, bus.data_wdata, e.wdata);
    end
  endtask

  // d_dly < 0: addr_ok and data_ok in the same cycle. Leaves handshake inputs asserted.
  task automatic serve(input string tag, input int a_dly, input int d_dly,
                       input logic [31:0] rd, input logic exp_stall);
    wait_req(tag);
    repeat (a_dly) begin
      step(); settle();
      chk({tag, "_req_hold"}, 32'(bus.data_req), 32'd1);
    end
    bus.data_addr_ok = 1'b1;
    if (d_dly < 0) begin
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = rd;
      settle();
    end else begin
      step();
      bus.data_addr_ok = 1'b0;
      settle();
      chk({tag, "_req_low_data"}, 32'(bus.data_req), 32'd0);
      repeat (d_dly) begin
        chk({tag, "_stall_wait"}, 32'(bus.stall), 32'd1);
        step(); settle();
      end
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = rd;
      settle();
    end
    chk({tag, "_stall_last"}, 32'(bus.stall), 32'(exp_stall));
  endtask

  task automatic release_bus();
    step();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    resetn = 1'b0;
    bus.flush = 1'b0;
    bus.m_req = 1'b0; bus.s_req = 1'b0;
    bus.m_wen = '0;   bus.s_wen = '0;
    bus.m_rlen = '0;  bus.s_rlen = '0;
    bus.m_addr = '0;  bus.s_addr = '0;
    bus.m_wdata = '0; bus.s_wdata = '0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;

    // Reset state
    repeat (3) step();
    settle();
    chk("rst_state",   32'(dut.r_state), 32'(IDLE));
    chk("rst_data_req", 32'(bus.data_req), 32'd0);
    chk("rst_stall",   32'(bus.stall), 32'd0);
    chk("rst_m_rdata", bus.m_rdata, 32'd0);
    chk("rst_s_rdata", bus.s_rdata, 32'd0);
    resetn = 1'b1;
    step();

    // Single master load, addr_ok cycle 1, data_ok cycle 3
    bus.m_req = 1'b1; bus.m_wen = 4'b0000; bus.m_rlen = 2'd2; bus.m_addr = 32'h8000_1000;
    push_exp(1'b0, SIZE_W, 32'h8000_1000, 4'b0000, 32'h0);
    settle();
    chk("s1_c0_stall", 32'(bus.stall), 32'd1);
    chk("s1_c0_req",   32'(bus.data_req), 32'd0);
    serve("s1", 0, 1, 32'hDEAD_BEEF, 1'b0);
    chk("s1_bypass", bus.m_rdata, 32'hDEAD_BEEF);
    release_bus();
    bus.m_req = 1'b0;
    settle();
    chk("s1_m_rdata_reg", bus.m_rdata, 32'hDEAD_BEEF);
    chk("s1_idle",  32'(dut.r_state), 32'(IDLE));
    chk("s1_stall", 32'(bus.stall), 32'd0);

    // Master SW then slave LW, program order
    bus.m_req = 1'b1; bus.m_wen = 4'b1111; bus.m_addr = 32'h100; bus.m_wdata = 32'h1122_3344;
    bus.s_req = 1'b1; bus.s_wen = 4'b0000; bus.s_rlen = 2'd2; bus.s_addr = 32'h104;
    push_exp(1'b1, SIZE_W, 32'h100, 4'b1111, 32'h1122_3344);
    push_exp(1'b0, SIZE_W, 32'h104, 4'b0000, 32'h0);
    settle();
    serve("s2w", 0, 0, 32'h0, 1'b1);
    chk("s2_m_rdata_kept", bus.m_rdata, 32'hDEAD_BEEF);
    release_bus();
    settle();
    chk("s2_back_to_addr", 32'(dut.r_state), 32'(ADDR));
    serve("s2r", 1, 0, 32'hCAFE_F00D, 1'b0);
    chk("s2_s_bypass", bus.s_rdata, 32'hCAFE_F00D);
    release_bus();
    bus.m_req = 1'b0; bus.s_req = 1'b0;
    settle();
    chk("s2_s_rdata_reg", bus.s_rdata, 32'hCAFE_F00D);
    chk("s2_stall_free",  32'(bus.stall), 32'd0);

    // Master SB, same-cycle addr_ok/data_ok
    bus.m_req = 1'b1; bus.m_wen = 4'b0100; bus.m_addr = 32'h302; bus.m_wdata = 32'hABAB_ABAB;
    push_exp(1'b1, SIZE_B, 32'h302, 4'b0100, 32'hABAB_ABAB);
    settle();
    serve("s3", 0, -1, 32'h0, 1'b0);
    release_bus();
    bus.m_req = 1'b0; bus.m_wen = 4'b0000;
    settle();
    chk("s3_idle",     32'(dut.r_state), 32'(IDLE));
    chk("s3_m_rdata",  bus.m_rdata, 32'hDEAD_BEEF);

    // Flush during DATA, drain, then a new request
    bus.m_req = 1'b1; bus.m_rlen = 2'd2; bus.m_addr = 32'h400;
    push_exp(1'b0, SIZE_W, 32'h400, 4'b0000, 32'h0);
    settle();
    wait_req("s4a");
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    settle();
    chk("s4_in_data", 32'(dut.r_state), 32'(DATA));
    bus.flush = 1'b1; bus.m_req = 1'b0;
    settle();
    chk("s4_flush_stall", 32'(bus.stall), 32'd0);
    step();
    bus.flush = 1'b0; bus.m_req = 1'b1; bus.m_addr = 32'h500;
    push_exp(1'b0, SIZE_W, 32'h500, 4'b0000, 32'h0);
    settle();
    chk("s4_drain",       32'(dut.r_state), 32'(DRAIN));
    chk("s4_drain_stall", 32'(bus.stall), 32'd1);
    chk("s4_drain_req",   32'(bus.data_req), 32'd0);
    step(); settle();
    chk("s4_drain_hold",  32'(dut.r_state), 32'(DRAIN));
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BAD_BAD0;
    settle();
    chk("s4_no_bypass",   bus.m_rdata, 32'hDEAD_BEEF);
    chk("s4_drain_ok_stall", 32'(bus.stall), 32'd1);
    step();
    bus.data_data_ok = 1'b0;
    settle();
    chk("s4_after_drain", 32'(dut.r_state), 32'(IDLE));
    chk("s4_discarded",   bus.m_rdata, 32'hDEAD_BEEF);
    serve("s4b", 0, 0, 32'h5566_7788, 1'b0);
    chk("s4b_bypass", bus.m_rdata, 32'h5566_7788);
    release_bus();
    bus.m_req = 1'b0;
    settle();

    // Same-word loads LW 0x200 / LB 0x203
    bus.m_req = 1'b1; bus.m_wen = 4'b0000; bus.m_rlen = 2'd2; bus.m_addr = 32'h200;
    bus.s_req = 1'b1; bus.s_wen = 4'b0000; bus.s_rlen = 2'd0; bus.s_addr = 32'h203;
`ifdef SAME_WORD_LOAD_MERGE_EN
    push_exp(1'b0, SIZE_W, 32'h200, 4'b0000, 32'h0);
    settle();
    serve("s5", 0, 0, 32'h4433_2211, 1'b0);
    chk("s5_m_bypass", bus.m_rdata, 32'h4433_2211);
    chk("s5_s_bypass", bus.s_rdata, 32'h4433_2211);
    release_bus();
    bus.m_req = 1'b0; bus.s_req = 1'b0;
    settle();
    chk("s5_m_reg", bus.m_rdata, 32'h4433_2211);
    chk("s5_s_reg", bus.s_rdata, 32'h4433_2211);
`else
    push_exp(1'b0, SIZE_W, 32'h200, 4'b0000, 32'h0);
    push_exp(1'b0, SIZE_B, 32'h203, 4'b0000, 32'h0);
    settle();
    serve("s5m", 0, 0, 32'h4433_2211, 1'b1);
    release_bus();
    settle();
    serve("s5s", 0, 0, 32'h9988_7766, 1'b0);
    chk("s5_s_bypass", bus.s_rdata, 32'h9988_7766);
    release_bus();
    bus.m_req = 1'b0; bus.s_req = 1'b0;
    settle();
    chk("s5_m_reg", bus.m_rdata, 32'h4433_2211);
    chk("s5_s_reg", bus.s_rdata, 32'h9988_7766);
`endif

    // Reset asserted while in ADDR
    bus.m_req = 1'b1; bus.m_rlen = 2'd2; bus.m_addr = 32'h600;
    push_exp(1'b0, SIZE_W, 32'h600, 4'b0000, 32'h0);
    settle();
    wait_req("s6");
    resetn = 1'b0; bus.m_req = 1'b0;
    step(); settle();
    chk("s6_req_low",  32'(bus.data_req), 32'd0);
    chk("s6_idle",     32'(dut.r_state), 32'(IDLE));
    chk("s6_stall",    32'(bus.stall), 32'd0);
    chk("s6_m_rdata",  bus.m_rdata, 32'd0);
    chk("s6_s_rdata",  bus.s_rdata, 32'd0);
    resetn = 1'b1;
    step();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
